// File: rtl/button_press_pulser.sv
// button_press_pulser
// Turns a debounced button level into a press strobe, auto-repeat strobes
// while the button is held, and a release strobe when an accepted press ends.
// A button that is already down when the block comes out of reset or is
// re-enabled is ignored until it has been seen released.
module button_press_pulser #(
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 12_500_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic enable,
  output logic press_pulse,
  output logic repeat_flag,
  output logic release_pulse,
  output logic held
);

  localparam logic [1:0] ST_LOCKOUT = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_REPEAT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             press_nxt_s;
  logic             repeat_nxt_s;
  logic             release_nxt_s;
  logic             held_nxt_s;

  // Next-state, counter and strobe decode; disable overrides every state.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    press_nxt_s   = 1'b0;
    repeat_nxt_s  = 1'b0;
    release_nxt_s = 1'b0;
    if (!enable) begin
      // Aborted hold: go quiet without a release strobe.
      state_nxt_s = ST_LOCKOUT;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_LOCKOUT: begin
          cnt_nxt_s = CNT_ZERO;
          if (!btn_level) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_LOCKOUT;
          end
        end
        ST_IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          if (btn_level) begin
            state_nxt_s = ST_WAIT;
            press_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!btn_level) begin
            // Release wins over a repeat falling due on the same edge.
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            release_nxt_s = 1'b1;
          end else if (cnt_r == HOLD_LAST) begin
            state_nxt_s  = ST_REPEAT;
            cnt_nxt_s    = CNT_ZERO;
            press_nxt_s  = 1'b1;
            repeat_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!btn_level) begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            release_nxt_s = 1'b1;
          end else if (cnt_r == REPEAT_LAST) begin
            cnt_nxt_s    = CNT_ZERO;
            press_nxt_s  = 1'b1;
            repeat_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_LOCKOUT;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
    held_nxt_s = (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_REPEAT);
  end

  // State, counter and registered outputs; reset parks the block in lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_LOCKOUT;
      cnt_r         <= CNT_ZERO;
      press_pulse   <= 1'b0;
      repeat_flag   <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      press_pulse   <= press_nxt_s;
      repeat_flag   <= repeat_nxt_s;
      release_pulse <= release_nxt_s;
      held          <= held_nxt_s;
    end
  end

endmodule
